// File: rtl/operand_fetch_pkg.sv
// Shared widths and register-index types for the operand fetch stage.
package operand_fetch_pkg;
  localparam int XLEN      = 32;
  localparam int CTRL_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_RD    = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode/regfile/writeback/execute signal bundle around the operand fetch stage.
interface operand_fetch_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32
);
  import operand_fetch_pkg::*;

  logic              in_valid;
  logic              in_ready;
  reg_idx_t          in_rs1;
  reg_idx_t          in_rs2;
  logic [CTRL_W-1:0] in_ctrl;
  reg_idx_t          rf_addr1;
  reg_idx_t          rf_addr2;
  logic [XLEN-1:0]   rf_data1;
  logic [XLEN-1:0]   rf_data2;
  logic              wb_en;
  reg_idx_t          wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_ctrl, rf_data1, rf_data2,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rf_addr1, rf_addr2, out_valid, out_rs1_val, out_rs2_val, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_ctrl, rf_data1, rf_data2,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rf_addr1, rf_addr2, out_valid, out_rs1_val, out_rs2_val, out_ctrl
  );
endinterface

// File: rtl/operand_fetch_bypass.sv
// One read port's writeback bypass and x0 masking on top of a registered regfile read.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_idx_t        rd_addr,
  input  reg_idx_t        held_idx,
  input  logic            wb_en,
  input  reg_idx_t        wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] rf_data,
  output logic [XLEN-1:0] val
);
  logic            byp_q;
  logic [XLEN-1:0] wbd_q;

  // The regfile returns pre-write data when read and write hit the same edge,
  // so remember the colliding write and substitute it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
      wbd_q <= '0;
    end else begin
      byp_q <= wb_en && (wb_addr == rd_addr);
      wbd_q <= wb_data;
    end
  end

  assign val = (held_idx == REG_ZERO) ? '0 :
               byp_q                  ? wbd_q : rf_data;
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: handshake with decode/execute, regfile read addressing, per-port bypass.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN   = operand_fetch_pkg::XLEN,
  parameter int CTRL_W = operand_fetch_pkg::CTRL_W
) (
  input logic           clk,
  input logic           rst_n,
  operand_fetch_if.slave bus
);
  logic                                out_valid_q;
  logic [CTRL_W-1:0]                   ctrl_q;
  logic [NUM_RD-1:0][REG_IDX_W-1:0]    held_q;
  logic [NUM_RD-1:0][REG_IDX_W-1:0]    in_rs;
  logic [NUM_RD-1:0][REG_IDX_W-1:0]    rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]         rf_data;
  logic [NUM_RD-1:0][XLEN-1:0]         val;
  logic                                accept;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign in_rs   = {bus.in_rs2, bus.in_rs1};
  assign rf_data = {bus.rf_data2, bus.rf_data1};

  // While stalled the held indices keep being re-read so late writes show up.
  assign rd_addr      = accept ? in_rs : held_q;
  assign bus.rf_addr1 = rd_addr[0];
  assign bus.rf_addr2 = rd_addr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      held_q      <= '0;
      ctrl_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      held_q      <= in_rs;
      ctrl_q      <= bus.in_ctrl;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    operand_bypass #(.XLEN(XLEN)) u_byp (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr[g]),
      .held_idx (held_q[g]),
      .wb_en    (bus.wb_en),
      .wb_addr  (bus.wb_addr),
      .wb_data  (bus.wb_data),
      .rf_data  (rf_data[g]),
      .val      (val[g])
    );
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_rs1_val = val[0];
  assign bus.out_rs2_val = val[1];
endmodule
